// File: rtl/pc_sequencer.sv
// Program counter and next-PC selection for the single-cycle MIPS datapath,
// with a one-cycle boot state, stall hold, halt/resume control and a sticky JR misalignment flag.
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          WIDTH        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             halt_req,
    input  logic             resume,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_offset,
    input  logic             jump_en,
    input  logic [WIDTH-1:0] jump_target,
    input  logic             jr_en,
    input  logic [WIDTH-1:0] jr_addr,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus4,
    output logic             fetch_valid,
    output logic             halted,
    output logic             misalign_err
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] pc_next;
    logic [WIDTH-1:0] target_pc;
    logic             err_next;

    assign pc_plus4    = pc + WIDTH'(4);
    assign fetch_valid = (state == RUN) && !stall;
    assign halted      = (state == HALT);

    // Fixed-priority target selection; all arithmetic wraps modulo 2^32.
    always_comb begin
        target_pc = pc_plus4;
        if (jr_en) begin
            target_pc = {jr_addr[WIDTH-1:2], 2'b00};
        end else if (jump_en) begin
            target_pc = jump_target;
        end else if (branch_taken) begin
            target_pc = pc_plus4 + (branch_offset << 2);
        end
    end

    always_comb begin
        state_next = state;
        pc_next    = pc;
        err_next   = misalign_err;
        case (state)
            BOOT: begin
                state_next = RUN;
            end
            RUN: begin
                if (halt_req) begin
                    state_next = HALT;
                end else if (!stall) begin
                    pc_next = target_pc;
                    if (jr_en && (jr_addr[1:0] != 2'b00)) begin
                        err_next = 1'b1;
                    end
                end
            end
            HALT: begin
                if (resume) begin
                    state_next = RUN;
                end
            end
            default: begin
                state_next = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= BOOT;
            pc           <= RESET_VECTOR;
            misalign_err <= 1'b0;
        end else begin
            state        <= state_next;
            pc           <= pc_next;
            misalign_err <= err_next;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized cycles
// compared against a behavioural model of the PC update rules.
module tb_pc_sequencer;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        halt_req;
    logic        resume;
    logic        branch_taken;
    logic [31:0] branch_offset;
    logic        jump_en;
    logic [31:0] jump_target;
    logic        jr_en;
    logic [31:0] jr_addr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        fetch_valid;
    logic        halted;
    logic        misalign_err;

    int n_compared;
    int n_mismatched;

    // Behavioural model: phase flags and an abstract PC value
    logic [31:0] m_pc;
    bit          m_boot;
    bit          m_halt;
    bit          m_err;

    pc_sequencer #(
        .RESET_VECTOR(32'h0000_0000),
        .WIDTH       (32)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .halt_req     (halt_req),
        .resume       (resume),
        .branch_taken (branch_taken),
        .branch_offset(branch_offset),
        .jump_en      (jump_en),
        .jump_target  (jump_target),
        .jr_en        (jr_en),
        .jr_addr      (jr_addr),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .fetch_valid  (fetch_valid),
        .halted       (halted),
        .misalign_err (misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        stall         = 1'b0;
        halt_req      = 1'b0;
        resume        = 1'b0;
        branch_taken  = 1'b0;
        branch_offset = 32'd0;
        jump_en       = 1'b0;
        jump_target   = 32'd0;
        jr_en         = 1'b0;
        jr_addr       = 32'd0;
    endtask

    task automatic model_reset();
        m_pc   = 32'h0000_0000;
        m_boot = 1'b1;
        m_halt = 1'b0;
        m_err  = 1'b0;
    endtask

    // Applies the architectural rules for one rising edge using the inputs present at that edge
    task automatic model_edge();
        if (m_boot) begin
            m_boot = 1'b0;
        end else if (m_halt) begin
            if (resume) m_halt = 1'b0;
        end else if (halt_req) begin
            m_halt = 1'b1;
        end else if (!stall) begin
            if (jr_en) begin
                m_pc = jr_addr - (jr_addr % 4);
                if ((jr_addr % 4) != 0) m_err = 1'b1;
            end else if (jump_en) begin
                m_pc = jump_target;
            end else if (branch_taken) begin
                m_pc = m_pc + 32'd4 + branch_offset * 32'd4;
            end else begin
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_inputs();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic go_to(input logic [31:0] addr);
        clear_inputs();
        jump_en     = 1'b1;
        jump_target = addr;
        step();
        clear_inputs();
    endtask

    task automatic test_reset();
        logic [31:0] exp_pc [4];
        exp_pc = '{32'h0, 32'h0, 32'h4, 32'h8};
        do_reset();
        n_compared++;
        if (pc_plus4 !== 32'h4) begin
            n_mismatched++;
            $display("[TB] FAIL reset_pc_plus4 actual=%h required=%h", pc_plus4, 32'h4);
        end
        n_compared++;
        if (halted !== 1'b0 || misalign_err !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_flags actual=%b%b required=00", halted, misalign_err);
        end
        for (int i = 0; i < 4; i++) begin
            if (i > 0) step();
            n_compared++;
            if (pc !== exp_pc[i]) begin
                n_mismatched++;
                $display("[TB] FAIL boot_pc[%0d] actual=%h required=%h", i, pc, exp_pc[i]);
            end
            n_compared++;
            if (fetch_valid !== (i > 0)) begin
                n_mismatched++;
                $display("[TB] FAIL boot_fetch_valid[%0d] actual=%b required=%b", i, fetch_valid, (i > 0));
            end
        end
    endtask

    task automatic test_priority();
        go_to(32'h100);
        jr_en       = 1'b1;
        jr_addr     = 32'h2000;
        jump_en     = 1'b1;
        jump_target = 32'h400;
        step();
        n_compared++;
        if (pc !== 32'h2000) begin
            n_mismatched++;
            $display("[TB] FAIL jr_over_jump actual=%h required=%h", pc, 32'h2000);
        end
        jr_en        = 1'b0;
        branch_taken = 1'b1;
        branch_offset = 32'h10;
        step();
        clear_inputs();
        n_compared++;
        if (pc !== 32'h400) begin
            n_mismatched++;
            $display("[TB] FAIL jump_over_branch actual=%h required=%h", pc, 32'h400);
        end
    endtask

    task automatic test_branch_wrap();
        go_to(32'h40);
        branch_taken  = 1'b1;
        branch_offset = 32'hFFFF_FFFE;
        step();
        clear_inputs();
        n_compared++;
        if (pc !== 32'h3C) begin
            n_mismatched++;
            $display("[TB] FAIL branch_negative actual=%h required=%h", pc, 32'h3C);
        end
        go_to(32'hFFFF_FFFC);
        n_compared++;
        if (pc_plus4 !== 32'h0) begin
            n_mismatched++;
            $display("[TB] FAIL pc_plus4_wrap actual=%h required=%h", pc_plus4, 32'h0);
        end
        step();
        n_compared++;
        if (pc !== 32'h0) begin
            n_mismatched++;
            $display("[TB] FAIL pc_wrap actual=%h required=%h", pc, 32'h0);
        end
    endtask

    task automatic test_stall();
        go_to(32'h80);
        stall       = 1'b1;
        jump_en     = 1'b1;
        jump_target = 32'h1234;
        #1;
        n_compared++;
        if (fetch_valid !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL stall_fetch_valid actual=%b required=0", fetch_valid);
        end
        step();
        n_compared++;
        if (pc !== 32'h80) begin
            n_mismatched++;
            $display("[TB] FAIL stall_hold actual=%h required=%h", pc, 32'h80);
        end
        stall = 1'b0;
        step();
        clear_inputs();
        n_compared++;
        if (pc !== 32'h1234) begin
            n_mismatched++;
            $display("[TB] FAIL stall_release actual=%h required=%h", pc, 32'h1234);
        end
    endtask

    task automatic test_halt_resume();
        go_to(32'h10);
        halt_req = 1'b1;
        step();
        halt_req    = 1'b0;
        jump_en     = 1'b1;
        jump_target = 32'h900;
        for (int i = 0; i < 5; i++) begin
            n_compared++;
            if (halted !== 1'b1 || pc !== 32'h10 || fetch_valid !== 1'b0) begin
                n_mismatched++;
                $display("[TB] FAIL halt_hold[%0d] actual=%b/%h/%b required=1/%h/0",
                         i, halted, pc, fetch_valid, 32'h10);
            end
            step();
        end
        clear_inputs();
        resume = 1'b1;
        step();
        resume = 1'b0;
        n_compared++;
        if (halted !== 1'b0 || pc !== 32'h10) begin
            n_mismatched++;
            $display("[TB] FAIL resume actual=%b/%h required=0/%h", halted, pc, 32'h10);
        end
        step();
        n_compared++;
        if (pc !== 32'h14) begin
            n_mismatched++;
            $display("[TB] FAIL resume_advance actual=%h required=%h", pc, 32'h14);
        end
    endtask

    task automatic test_misalign_reset();
        go_to(32'h500);
        stall   = 1'b1;
        jr_en   = 1'b1;
        jr_addr = 32'h1003;
        step();
        n_compared++;
        if (misalign_err !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL misalign_blocked actual=%b required=0", misalign_err);
        end
        stall = 1'b0;
        step();
        clear_inputs();
        n_compared++;
        if (pc !== 32'h1000 || misalign_err !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL misalign_set actual=%h/%b required=%h/1", pc, misalign_err, 32'h1000);
        end
        step();
        step();
        n_compared++;
        if (misalign_err !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL misalign_sticky actual=%b required=1", misalign_err);
        end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_compared++;
        if (pc !== 32'h0 || misalign_err !== 1'b0 || fetch_valid !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL async_reset actual=%h/%b/%b required=0/0/0", pc, misalign_err, fetch_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            stall         = ($urandom_range(0, 3) == 0);
            halt_req      = ($urandom_range(0, 15) == 0);
            resume        = ($urandom_range(0, 3) == 0);
            branch_taken  = $urandom_range(0, 1);
            branch_offset = ($urandom_range(0, 1) == 1) ? $urandom : {{16{1'b1}}, 16'($urandom)};
            jump_en       = ($urandom_range(0, 5) == 0);
            jump_target   = $urandom;
            jr_en         = ($urandom_range(0, 7) == 0);
            jr_addr       = $urandom;
            step();
            n_compared++;
            if (pc !== m_pc || pc_plus4 !== m_pc + 32'd4 || halted !== m_halt ||
                misalign_err !== m_err || fetch_valid !== (!m_boot && !m_halt && !stall)) begin
                n_mismatched++;
                $display("[TB] FAIL random[%0d] actual pc=%h p4=%h h=%b e=%b fv=%b required pc=%h h=%b e=%b fv=%b",
                         i, pc, pc_plus4, halted, misalign_err, fetch_valid,
                         m_pc, m_halt, m_err, (!m_boot && !m_halt && !stall));
            end
        end
        clear_inputs();
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        rst_n        = 1'b1;
        clear_inputs();
        model_reset();
        test_reset();
        test_priority();
        test_branch_wrap();
        test_stall();
        test_halt_resume();
        test_misalign_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
